// File: rtl/reflet_byte_bus_bridge_if.sv
// Bus bundle for reflet_byte_bus_bridge.
// Word side: an aligned word request/response channel.
//   word_addr, word_data_in, word_write_en, word_read_en  (requester -> bridge)
//   word_data_out, word_ready, bus_error                  (bridge -> requester)
// Byte side: an 8-bit memory channel with a ready handshake.
//   byte_addr, byte_data_out, byte_write_en, byte_read_en (bridge -> memory)
//   byte_data_in, byte_ready                              (memory -> bridge)
// Modports:
//   slave  - the bridge (responder on the word side, initiator on the byte side)
//   master - the surrounding system (requester plus byte memory)
interface reflet_byte_bus_bridge_if #(
  parameter int word_size = 32,
  parameter int addr_size = 32
);
  logic [addr_size-1:0] word_addr;
  logic [word_size-1:0] word_data_in;
  logic [word_size-1:0] word_data_out;
  logic                 word_write_en;
  logic                 word_read_en;
  logic                 word_ready;
  logic                 bus_error;

  logic [addr_size-1:0] byte_addr;
  logic [7:0]           byte_data_out;
  logic [7:0]           byte_data_in;
  logic                 byte_write_en;
  logic                 byte_read_en;
  logic                 byte_ready;

  modport slave (
    input  word_addr, word_data_in, word_write_en, word_read_en,
    input  byte_data_in, byte_ready,
    output word_data_out, word_ready, bus_error,
    output byte_addr, byte_data_out, byte_write_en, byte_read_en
  );

  modport master (
    output word_addr, word_data_in, word_write_en, word_read_en,
    output byte_data_in, byte_ready,
    input  word_data_out, word_ready, bus_error,
    input  byte_addr, byte_data_out, byte_write_en, byte_read_en
  );
endinterface

// File: rtl/reflet_byte_bus_bridge.sv
// reflet_byte_bus_bridge
// Serves aligned word reads/writes by running word_size/8 sequential little-endian byte
// transfers on a byte-wide memory bus, with a per-byte stall timeout.
// Ports:
//   clk    - single clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - reflet_byte_bus_bridge_if.slave (word request side and byte memory side)
// Parameters:
//   word_size      - word width in bits (multiple of 8, >= 16)
//   addr_size      - width of both address buses
//   timeout_cycles - max wait cycles per byte before bus_error; 0 disables the timeout
module reflet_byte_bus_bridge #(
  parameter int word_size      = 32,
  parameter int addr_size      = 32,
  parameter int timeout_cycles = 255
) (
  input logic                          clk,
  input logic                          reset,
  reflet_byte_bus_bridge_if.slave      bus
);
  localparam int n_bytes = word_size / 8;
  localparam int idx_w   = $clog2(n_bytes);
  localparam int wait_w  = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;

  localparam logic [idx_w-1:0]     last_idx   = idx_w'(n_bytes - 1);
  localparam logic [addr_size-1:0] align_mask = ~addr_size'(n_bytes - 1);
  localparam logic [wait_w-1:0]    wait_limit = wait_w'(timeout_cycles - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t               state, state_next;
  logic [idx_w-1:0]     idx;
  logic [wait_w-1:0]    wait_cnt;
  logic [addr_size-1:0] base;
  logic [word_size-1:0] wdata;
  logic [word_size-1:0] rbuf;      // bytes gathered by the current read
  logic [word_size-1:0] data_out;  // last completed read, held between reads
  logic                 is_write;
  logic                 err_flag;
  logic                 timed_out;

  wire request = bus.word_write_en | bus.word_read_en;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next        = state;
    timed_out         = 1'b0;
    bus.byte_write_en = 1'b0;
    bus.byte_read_en  = 1'b0;
    bus.byte_addr     = '0;
    bus.byte_data_out = '0;
    bus.word_ready    = 1'b0;
    bus.bus_error     = 1'b0;
    bus.word_data_out = data_out;

    case (state)
      IDLE: begin
        if (request) state_next = XFER;
      end
      XFER: begin
        bus.byte_write_en = is_write;
        bus.byte_read_en  = ~is_write;
        bus.byte_addr     = base + addr_size'(idx);
        bus.byte_data_out = wdata[{idx, 3'b000} +: 8];
        if (bus.byte_ready) begin
          if (idx == last_idx) state_next = DONE;
        end else if (timeout_cycles != 0 && wait_cnt == wait_limit) begin
          // This wait is the timeout_cycles-th for the current byte.
          timed_out  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        bus.word_ready = 1'b1;
        bus.bus_error  = err_flag;
        // Present the fresh read result during the completion cycle itself.
        if (!is_write) bus.word_data_out = rbuf;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      wait_cnt <= '0;
      base     <= '0;
      wdata    <= '0;
      rbuf     <= '0;
      data_out <= '0;
      is_write <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            base     <= bus.word_addr & align_mask;
            wdata    <= bus.word_data_in;
            is_write <= bus.word_write_en;  // write wins when both are requested
            idx      <= '0;
            wait_cnt <= '0;
            rbuf     <= '0;                 // bytes skipped by a timeout read as 0
            err_flag <= 1'b0;
          end
        end
        XFER: begin
          if (bus.byte_ready) begin
            if (!is_write) rbuf[{idx, 3'b000} +: 8] <= bus.byte_data_in;
            wait_cnt <= '0;
            if (idx != last_idx) idx <= idx + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timed_out) err_flag <= 1'b1;
          end
        end
        DONE: begin
          if (!is_write) data_out <= rbuf;
          idx      <= '0;
          wait_cnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
